// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one native memory port; grant registered (1 cycle valid->s_valid), datapath combinational.
// Backpressure: the granted master stalls on s_ready; the other master waits, no preemption; optional watchdog faults a stall.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m0_lock,
  output logic        m0_access_fault,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  input  logic        m1_lock,
  output logic        m1_access_fault,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_access_fault,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam bit                       WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     last_q, last_d;  // 1 = m1 owned the last finished access
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

  logic        own1;
  logic        g_valid, g_lock;
  logic [3:0]  g_wstrb;
  logic [31:0] g_addr, g_wdata;
  logic        timeout;
  logic        g_rdy, g_flt;
  logic [31:0] g_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  assign own1    = (state_q == GNT1);
  assign g_valid = own1 ? m1_valid : m0_valid;
  assign g_lock  = own1 ? m1_lock  : m0_lock;
  assign g_wstrb = own1 ? m1_wstrb : m0_wstrb;
  assign g_addr  = own1 ? m1_addr  : m0_addr;
  assign g_wdata = own1 ? m1_wdata : m0_wdata;

  // A slave response in the expiry cycle wins over the watchdog.
  assign timeout = WD_EN && (state_q == GNT0 || state_q == GNT1) &&
                   g_valid && !s_ready && (wd_q == WD_LAST);

  assign g_rdy = s_ready | timeout;
  assign g_flt = (s_access_fault & s_ready) | timeout;
  assign g_rd  = timeout ? 32'h0 : s_rdata;

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    wd_d            = wd_q;
    s_valid         = 1'b0;
    s_wstrb         = '0;
    s_addr          = '0;
    s_wdata         = '0;
    grant           = 2'b00;
    m0_ready        = 1'b0;
    m0_access_fault = 1'b0;
    m0_rdata        = '0;
    m1_ready        = 1'b0;
    m1_access_fault = 1'b0;
    m1_rdata        = '0;

    case (state_q)
      GNT0, GNT1: begin
        s_valid = g_valid & ~timeout;
        s_wstrb = g_wstrb;
        s_addr  = g_addr;
        s_wdata = g_wdata;
        grant   = own1 ? 2'b10 : 2'b01;
        if (own1) begin
          m1_ready        = g_rdy;
          m1_access_fault = g_flt;
          m1_rdata        = g_rd;
        end else begin
          m0_ready        = g_rdy;
          m0_access_fault = g_flt;
          m0_rdata        = g_rd;
        end

        if (g_valid && s_ready) begin
          last_d = own1;
          wd_d   = '0;
          if (!g_lock) state_d = IDLE;
        end else if (timeout) begin
          last_d  = own1;
          wd_d    = '0;
          state_d = IDLE;
        end else if (!g_valid && !g_lock) begin
          wd_d    = '0;
          state_d = IDLE;
        end else if (g_valid && WD_EN) begin
          wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        wd_d = '0;
        if (m0_valid && m1_valid) state_d = last_q ? GNT0 : GNT1;
        else if (m0_valid)        state_d = GNT0;
        else if (m1_valid)        state_d = GNT1;
        else                      state_d = IDLE;
      end
    endcase
  end

endmodule
